// File: rtl/mmio_uart_tx.sv
// Generic single-clock FIFO with combinational head and count-based empty/full.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: caller gates push on !full (or a same-edge pop) and pop on !empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_rdy) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_vld, pop_rdy})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));

endmodule

// Memory-mapped 8N1 UART transmitter: TXDATA at BASE_ADDR, STATUS at BASE_ADDR+1.
// Latency: push into an empty FIFO while idle starts the start bit one cycle later.
// Backpressure: writes to a full FIFO are dropped and latch the sticky overflow bit.
module mmio_uart_tx #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 8'hC0,
    parameter int                    CLKS_PER_BIT = 16,
    parameter int                    FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] adr,
    input  logic [DATA_WIDTH-1:0] writedata,
    input  logic                  memwrite,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  tx,
    output logic                  busy
);
    localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = BASE_ADDR + 1'b1;
    localparam int                    BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ovf_q;

    logic              baud_end;
    logic              pop;
    logic              push;
    logic              wr_data_sel;
    logic              wr_stat_sel;
    logic              ovf_set;
    logic              ovf_clr;
    logic [7:0]        fifo_head;
    logic              fifo_empty;
    logic              fifo_full;
    logic [7:0]        status;

    assign wr_data_sel = memwrite && (adr == BASE_ADDR);
    assign wr_stat_sel = memwrite && (adr == STAT_ADDR);

    // A full FIFO still accepts a write on the edge where the shifter drains a slot.
    assign push    = wr_data_sel && (!fifo_full || pop);
    assign ovf_set = wr_data_sel && fifo_full && !pop;
    assign ovf_clr = wr_stat_sel && writedata[3];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push_vld (push),
        .push_dat (writedata[7:0]),
        .pop_rdy  (pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign baud_end = (baud_q == BAUD_LAST);

    // tx_d carries the line level of the state being entered, so tx stays a flop output.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    baud_d  = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Set beats clear when both land on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign status = {4'b0000, ovf_q, (state_q != IDLE), fifo_full, fifo_empty};
    assign hit    = (adr == BASE_ADDR) || (adr == STAT_ADDR);
    assign rdata  = (adr == STAT_ADDR) ? DATA_WIDTH'(status) : '0;
    assign tx     = tx_q;
    assign busy   = (state_q != IDLE) || !fifo_empty;

endmodule
